// File: rtl/iomem_pkg.sv
// Shared bus widths and decode helpers for the iomem peripheral slice.
// Kept tiny so other iomem slaves can reuse the same decode rules.
package iomem_pkg;

  localparam int unsigned AW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned PW = 16;

  function automatic logic page_hit(
    input logic [AW-1:0] addr,
    input logic [PW-1:0] page
  );
    return addr[AW-1:AW-PW] == page;
  endfunction

  function automatic logic is_write(
    input logic [SW-1:0] wstrb
  );
    return |wstrb;
  endfunction

endpackage

// File: rtl/iomem.sv
// Address decode and one-cycle ready/we/re handshake for a single
// peripheral on the iomem bus; data paths live in the peripheral.
module iomem
  import iomem_pkg::*;
#(
  parameter logic [PW-1:0] ADDR = 16'h6000
) (
  input  logic          ck,
  input  logic          rst,
  input  logic          iomem_valid,
  input  logic [SW-1:0] iomem_wstrb,
  input  logic [AW-1:0] iomem_addr,
  output logic          ready,
  output logic          we,
  output logic          re
);

  logic sel;
  logic req;
  logic ready_d;
  logic we_d;
  logic re_d;
  logic unused_offset;

  // The low half is the peripheral's own offset and plays no part here.
  assign unused_offset = ^iomem_addr[AW-PW-1:0];

  always_comb begin
    sel     = iomem_valid & page_hit(iomem_addr, ADDR);
    // !ready keeps a still-held valid from being acked twice in a row.
    req     = sel & ~ready;
    ready_d = req;
    we_d    = req & is_write(iomem_wstrb);
    re_d    = req & ~is_write(iomem_wstrb);
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      ready <= 1'b0;
      we    <= 1'b0;
      re    <= 1'b0;
    end else begin
      ready <= ready_d;
      we    <= we_d;
      re    <= re_d;
    end
  end

endmodule

// File: tb/tb_iomem.sv
// Directed vector bench for iomem: table of bus cycles plus
// hand-written reset and held-request sequences.
module tb_iomem;

  logic        ck = 1'b0;
  logic        rst = 1'b0;
  logic        iomem_valid = 1'b0;
  logic [3:0]  iomem_wstrb = 4'h0;
  logic [31:0] iomem_addr = 32'h0;
  logic        ready;
  logic        we;
  logic        re;

  int n_vec = 0;
  int n_bad = 0;

  iomem #(.ADDR(16'h6000)) dut (
    .ck          (ck),
    .rst         (rst),
    .iomem_valid (iomem_valid),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .ready       (ready),
    .we          (we),
    .re          (re)
  );

  always #5 ck = ~ck;

  typedef struct {
    logic        valid;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [2:0]  exp;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input logic [2:0] exp);
    n_vec++;
    if ({ready, we, re} !== exp) begin
      n_bad++;
      $display("FAIL %s: got ready/we/re=%b, want %b",
               name, {ready, we, re}, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] s,
                       input logic [31:0] a);
    iomem_valid = v;
    iomem_wstrb = s;
    iomem_addr  = a;
  endtask

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 4'hf, 32'h6000_0000, 3'b110};
    tbl[1]  = '{1'b0, 4'hf, 32'h6000_0000, 3'b000};
    tbl[2]  = '{1'b1, 4'hf, 32'h6000_0004, 3'b110};
    tbl[3]  = '{1'b0, 4'h0, 32'h6000_0004, 3'b000};
    tbl[4]  = '{1'b1, 4'h0, 32'h6000_0004, 3'b101};
    tbl[5]  = '{1'b0, 4'h0, 32'h6000_0004, 3'b000};
    tbl[6]  = '{1'b1, 4'h3, 32'h6000_fffc, 3'b110};
    tbl[7]  = '{1'b0, 4'hf, 32'h6000_0000, 3'b000};
    tbl[8]  = '{1'b1, 4'hf, 32'h7000_0000, 3'b000};
    tbl[9]  = '{1'b1, 4'h0, 32'h5fff_ffff, 3'b000};
    tbl[10] = '{1'b1, 4'h0, 32'h6000_abcd, 3'b101};
    tbl[11] = '{1'b1, 4'h0, 32'h6000_abcd, 3'b000};
    tbl[12] = '{1'b1, 4'h0, 32'h6000_abcd, 3'b101};
    tbl[13] = '{1'b1, 4'h0, 32'h6000_abcd, 3'b000};
    tbl[14] = '{1'b1, 4'h1, 32'h6001_0000, 3'b000};
    tbl[15] = '{1'b0, 4'h0, 32'h6000_0000, 3'b000};

    // Matching request held during reset must not be acked.
    drive(1'b1, 4'hf, 32'h6000_0000);
    step();
    check("in_reset_0", 3'b000);
    step();
    check("in_reset_1", 3'b000);
    drive(1'b0, 4'h0, 32'h0);
    rst = 1'b1;
    step();
    check("post_reset_idle", 3'b000);

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].valid, tbl[i].wstrb, tbl[i].addr);
      step();
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Miss held for ten cycles never acks.
    drive(1'b1, 4'hf, 32'h7000_0000);
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("miss%0d", i), 3'b000);
    end
    drive(1'b0, 4'h0, 32'h0);
    step();

    // Async reset during a ready pulse clears it without an edge.
    drive(1'b1, 4'hf, 32'h6000_0010);
    step();
    check("pulse_before_rst", 3'b110);
    #1 rst = 1'b0;
    #1 check("async_clear", 3'b000);
    step();
    check("held_in_reset", 3'b000);
    // Release mid-cycle with a read still pending.
    drive(1'b1, 4'h0, 32'h6000_0010);
    rst = 1'b1;
    #1 check("just_released", 3'b000);
    step();
    check("ack_after_release", 3'b101);
    drive(1'b0, 4'h0, 32'h0);
    step();
    check("drop_after_release", 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/iomem.md
Name: iomem

Overview:
- Address decoder and handshake generator for one peripheral on the PicoRV32-style iomem bus.
- Matches bus requests whose upper address half equals parameter ADDR.
- Returns a single-cycle ready acknowledge, plus a single-cycle write strobe (we) or read strobe (re) to the peripheral logic.
- Carries no data; the peripheral drives read data and captures write data alongside the strobes.

Parameters:
- ADDR, 16'h6000, value compared against iomem_addr[31:16] to select this peripheral.

Ports:
- ck  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = in reset).
- iomem_valid  input  1  bus request valid; held by master until it sees ready.
- iomem_wstrb  input  4  byte write strobes; nonzero = write, 0000 = read.
- iomem_addr  input  32  request address.
- ready  output  1  registered acknowledge, one-cycle pulse.
- we  output  1  registered write strobe, one-cycle pulse coincident with ready.
- re  output  1  registered read strobe, one-cycle pulse coincident with ready.

Behaviour:
- Reset (rst=0, asynchronous): ready=0, we=0, re=0 immediately; held at 0 while rst=0.
- Decode: sel = iomem_valid & (iomem_addr[31:16] == ADDR). Address bits [15:0] are ignored; any offset within the 64 KiB window selects.
- Request qualification: req = sel & !ready.
- Registered outputs, updated each rising ck edge:
  - ready <= req.
  - we <= req & (iomem_wstrb != 0).
  - re <= req & (iomem_wstrb == 0).
- Latency: request present at rising edge N gives ready plus exactly one of we/re high for the cycle after edge N, low again after edge N+1.
- No back-to-back double acknowledge: the !ready term forces ready low on the following cycle even if valid is still high.
  - If valid is still high after that low cycle, it is treated as a new request and acknowledged again.
  - Masters must drop valid within one cycle of ready.
- we and re are mutually exclusive and never high without ready.
- Address miss (valid=1, upper half != ADDR): ready, we, re stay 0 indefinitely; another slave or the bus default responds.
- valid=0: outputs 0 regardless of addr/wstrb.
- Partial writes (e.g. wstrb=4'b0011) count as writes and assert we; byte-lane handling belongs to the peripheral.
- Reset mid-handshake clears the pulse. A request still valid after reset release is acknowledged one cycle after the first rising edge with rst=1.
- Inputs are sampled only at rising ck edges; changes between edges have no effect.

Decomposition:
- No shared package required.
- Any bus-width constant (32-bit address, 4-bit strobe) may live in the project's common bus package if one exists.
- Single flat module; no sub-module needed.

Test Plan:
- Write: rst released, valid=1, wstrb=4'hf, addr=32'h60000000 → ready=1 and we=1, re=0 for exactly one cycle, one cycle after sampling; master drops valid.
- Second write at offset: addr=32'h60000004, wstrb=4'hf → identical single-cycle ready+we pulse.
- Read: valid=1, wstrb=0, addr=32'h60000004 → ready=1, re=1, we=0 for exactly one cycle.
- Miss: valid=1, addr=32'h70000000, wstrb=4'hf held 10 cycles → ready, we, re remain 0 throughout.
- Valid held high after ack: read request held 4 cycles → ready pattern 1,0,1,0 with re pulsing alongside; never high on two consecutive cycles.
- Reset: hold rst=0 with a matching request → all outputs 0. Assert rst=0 asynchronously during a ready pulse → outputs drop immediately, without a clock edge.
